// File: rtl/had_satd_sched.sv
// had_satd_sched: sequencer for a shared 4x4 Hadamard SATD unit.
// Walks the 4x4 sub-blocks of a 4/8/16-pixel prediction block in raster
// order, one per cycle, and strobes the Hadamard enable/export lines in
// step with the fetch pipeline. It also sums the per-sub-block results into
// one block SATD.
// Every output comes straight from a flop.

module had_satd_sched #(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       blk_w_sel,
    input  logic [1:0]       blk_h_sel,
    input  logic [15:0]      had_4x4,
    output logic             fetch_req,
    output logic [1:0]       sub_x,
    output logic [1:0]       sub_y,
    output logic             had_en,
    output logic             had_export,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] satd
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Block-size code to number of 4-pixel sub-blocks along one side.
    // Codes 2 and 3 both mean 16 pixels.
    function automatic logic [2:0] sel_to_cnt(input logic [1:0] sel);
        logic [2:0] cnt;
        case (sel)
            2'd0:    cnt = 3'd1;
            2'd1:    cnt = 3'd2;
            default: cnt = 3'd4;
        endcase
        return cnt;
    endfunction

    logic [1:0]       state_q,   state_d;
    logic [2:0]       nx_q,      nx_d;
    logic [2:0]       ny_q,      ny_d;
    logic [4:0]       n_q,       n_d;
    logic [1:0]       sx_q,      sx_d;
    logic [1:0]       sy_q,      sy_d;
    logic             fetch_q,   fetch_d;
    logic [3:0]       v_q,       v_d;
    logic [4:0]       retire_q,  retire_d;
    logic [ACC_W-1:0] acc_q,     acc_d;
    logic [ACC_W-1:0] satd_q,    satd_d;
    logic             done_q,    done_d;
    logic             busy_q,    busy_d;

    logic [ACC_W-1:0] acc_sum_s;
    logic             row_end_s;
    logic             col_end_s;
    logic             last_issue_s;

    // Issue-position decode and the accumulator value including this cycle's retire.
    always_comb begin
        acc_sum_s    = acc_q + {{(ACC_W-16){1'b0}}, had_4x4};
        row_end_s    = ({1'b0, sx_q} == (nx_q - 3'd1));
        col_end_s    = ({1'b0, sy_q} == (ny_q - 3'd1));
        last_issue_s = row_end_s && col_end_s;
    end

    // Next-state logic: FSM, issue counters, valid pipeline and accumulator.
    always_comb begin
        state_d  = state_q;
        nx_d     = nx_q;
        ny_d     = ny_q;
        n_d      = n_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        fetch_d  = fetch_q;
        satd_d   = satd_q;
        done_d   = 1'b0;
        // The valid pipeline follows fetch_req with a one-cycle delay per stage.
        v_d      = {v_q[2:0], fetch_q};

        // Retire: v[3] marks the cycle in which had_4x4 belongs to an issued sub-block.
        if (v_q[3]) begin
            acc_d    = acc_sum_s;
            retire_d = retire_q + 5'd1;
        end else begin
            acc_d    = acc_q;
            retire_d = retire_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    nx_d     = sel_to_cnt(blk_w_sel);
                    ny_d     = sel_to_cnt(blk_h_sel);
                    n_d      = {2'b00, sel_to_cnt(blk_w_sel)} * {2'b00, sel_to_cnt(blk_h_sel)};
                    sx_d     = 2'd0;
                    sy_d     = 2'd0;
                    fetch_d  = 1'b1;
                    acc_d    = {ACC_W{1'b0}};
                    retire_d = 5'd0;
                    v_d      = 4'd0;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                // The sub-block at (sx_q, sy_q) is being issued now; choose the next one.
                if (last_issue_s) begin
                    state_d = S_DRAIN;
                    fetch_d = 1'b0;
                    sx_d    = 2'd0;
                    sy_d    = 2'd0;
                end else if (row_end_s) begin
                    sx_d    = 2'd0;
                    sy_d    = sy_q + 2'd1;
                end else begin
                    sx_d    = sx_q + 2'd1;
                end
            end
            S_DRAIN: begin
                // Leave on the cycle of the last retire, so satd captures the final sum.
                if (v_q[3] && ((retire_q + 5'd1) == n_q)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    satd_d  = acc_sum_s;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                fetch_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            nx_q     <= 3'd0;
            ny_q     <= 3'd0;
            n_q      <= 5'd0;
            sx_q     <= 2'd0;
            sy_q     <= 2'd0;
            fetch_q  <= 1'b0;
            v_q      <= 4'd0;
            retire_q <= 5'd0;
            acc_q    <= {ACC_W{1'b0}};
            satd_q   <= {ACC_W{1'b0}};
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            nx_q     <= nx_d;
            ny_q     <= ny_d;
            n_q      <= n_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            fetch_q  <= fetch_d;
            v_q      <= v_d;
            retire_q <= retire_d;
            acc_q    <= acc_d;
            satd_q   <= satd_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign fetch_req  = fetch_q;
    assign sub_x      = sx_q;
    assign sub_y      = sy_q;
    assign had_en     = v_q[0];
    assign had_export = v_q[2];
    assign busy       = busy_q;
    assign done       = done_q;
    assign satd       = satd_q;

endmodule

// File: tb/tb_had_satd_sched.sv
// Directed bench for had_satd_sched. A small fetch/Hadamard model answers
// the DUT's strobes, and a table of block shapes holds the expected SATDs.
// Hand-written sequences cover a start while busy and a reset mid-block.

module tb_had_satd_sched;

    localparam int ACC_W = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       blk_w_sel;
    logic [1:0]       blk_h_sel;
    logic [15:0]      had_4x4;
    logic             fetch_req;
    logic [1:0]       sub_x;
    logic [1:0]       sub_y;
    logic             had_en;
    logic             had_export;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] satd;

    int n_cmp = 0;
    int n_err = 0;

    // Model configuration: constant result, or one that depends on position.
    logic [15:0] cur_val   = 16'd0;
    logic        cur_coord = 1'b0;

    always #5 clk = ~clk;

    had_satd_sched #(.ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .blk_w_sel  (blk_w_sel),
        .blk_h_sel  (blk_h_sel),
        .had_4x4    (had_4x4),
        .fetch_req  (fetch_req),
        .sub_x      (sub_x),
        .sub_y      (sub_y),
        .had_en     (had_en),
        .had_export (had_export),
        .busy       (busy),
        .done       (done),
        .satd       (satd)
    );

    function automatic logic [15:0] samp_val(input logic [1:0] x, input logic [1:0] y);
        if (cur_coord)
            return 16'd10 * (16'd1 + {14'd0, x} + 16'd4 * {14'd0, y});
        else
            return cur_val;
    endfunction

    // Fetch unit plus Hadamard model. Sample data arrives one cycle after fetch_req.
    // Stage 1 is zeroed when had_en is low. The output register loads on had_export.
    logic [15:0] m_s0  = 16'd0;
    logic [15:0] m_s1  = 16'd0;
    logic [15:0] m_s2  = 16'd0;
    logic [15:0] m_out = 16'd0;
    always @(posedge clk) begin
        m_s0 <= fetch_req ? samp_val(sub_x, sub_y) : 16'd0;
        m_s1 <= had_en ? m_s0 : 16'd0;
        m_s2 <= m_s1;
        if (had_export) m_out <= m_s2;
    end
    assign had_4x4 = m_out;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Run one block. Cycle 0 samples start. Every cycle through N+7, check the
    // full control vector; from the done cycle on, also check satd.
    task automatic run_block(input int id, input logic [1:0] w, input logic [1:0] h,
                             input int nx, input int ny, input logic [ACC_W-1:0] exp_satd,
                             input int extra_start);
        int n;
        n = nx * ny;
        @(negedge clk);
        blk_w_sel = w;
        blk_h_sel = h;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= n + 7; c++) begin
            logic       f;
            int         idx;
            int         ex;
            int         ey;
            logic [1:0] exb;
            logic [1:0] eyb;
            logic [8:0] exp_ctrl;
            f   = (c <= n);
            idx = c - 1;
            ex  = f ? (idx % nx) : 0;
            ey  = f ? (idx / nx) : 0;
            exb = ex[1:0];
            eyb = ey[1:0];
            exp_ctrl = {f, exb, eyb, (c >= 2 && c <= n + 1), (c >= 4 && c <= n + 3),
                        (c <= n + 5), (c == n + 5)};
            chk($sformatf("blk%0d cyc%0d ctrl{fetch,x,y,en,exp,busy,done}", id, c),
                64'({fetch_req, sub_x, sub_y, had_en, had_export, busy, done}),
                64'(exp_ctrl));
            if (c >= n + 5)
                chk($sformatf("blk%0d cyc%0d satd", id, c), 64'(satd), 64'(exp_satd));
            if (c == extra_start) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    typedef struct {
        logic [1:0]       w;
        logic [1:0]       h;
        logic             coord;
        logic [15:0]      val;
        int               nx;
        int               ny;
        logic [ACC_W-1:0] exp_satd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit seen;
        // 4x4 with equal ref/cur samples: result 0
        vecs[0] = '{2'd0, 2'd0, 1'b0, 16'd0,     1, 1, 20'd0};
        // 8x8 constant 100 per sub-block
        vecs[1] = '{2'd1, 2'd1, 1'b0, 16'd100,   2, 2, 20'd400};
        // 16x16, every sub-block at maximum
        vecs[2] = '{2'd2, 2'd2, 1'b0, 16'd65535, 4, 4, 20'd1048560};
        // reserved width code 3 = 16, height 4
        vecs[3] = '{2'd3, 2'd0, 1'b0, 16'd7,     4, 1, 20'd28};
        // 4x16
        vecs[4] = '{2'd0, 2'd2, 1'b0, 16'd3,     1, 4, 20'd12};
        // 8x8 with position-dependent values 10,20,50,60
        vecs[5] = '{2'd1, 2'd1, 1'b1, 16'd0,     2, 2, 20'd140};

        rst_n     = 1'b0;
        start     = 1'b0;
        blk_w_sel = 2'd0;
        blk_h_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", 64'({fetch_req, sub_x, sub_y, had_en, had_export, busy, done, satd}),
            64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            cur_val   = vecs[i].val;
            cur_coord = vecs[i].coord;
            run_block(i, vecs[i].w, vecs[i].h, vecs[i].nx, vecs[i].ny, vecs[i].exp_satd, 0);
        end

        // A start in cycle 3 of an 8x8 run must be ignored
        cur_val   = 16'd100;
        cur_coord = 1'b0;
        run_block(10, 2'd1, 2'd1, 2, 2, 20'd400, 3);

        // Reset during cycle 5 of a 16x16 run
        cur_val = 16'd9;
        @(negedge clk);
        blk_w_sel = 2'd2;
        blk_h_sel = 2'd2;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("outputs after mid-block reset",
            64'({fetch_req, sub_x, sub_y, had_en, had_export, busy, done, satd}), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (done || busy || fetch_req) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("no activity after abandoned block", 64'(seen), 64'd0);

        cur_val = 16'd5;
        run_block(11, 2'd0, 2'd0, 1, 1, 20'd5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
